// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: fetch, decode, execute, memory, write-back.
// Define RV_CTRL_TRAP_EN to trap illegal encodings; otherwise they retire as a NOP.
module rv_multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        ir_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic        mem_unsigned,
    output logic [3:0]  alu_op,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        instr_done,
    output logic        illegal,
    output logic [31:0] retire_cnt
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    state_t      state_r;
    logic [31:0] retire_cnt_r;
    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic        illegal_enc_s;
    logic [3:0]  alu_op_s;
    logic [1:0]  alu_src_a_s;
    logic [1:0]  alu_src_b_s;
    logic        unused_instr_bits_s;

    function automatic logic enc_illegal(input logic [6:0] op, input logic [2:0] f3);
        logic bad;
        case (op)
            OP_LOAD:   bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            OP_STORE:  bad = (f3 >= 3'd3);
            OP_BRANCH: bad = (f3 == 3'd2) || (f3 == 3'd3);
            OP_R, OP_IMM, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL: bad = 1'b0;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Only register-register and immediate ALU instructions use funct3; the rest add.
    function automatic logic [3:0] alu_decode(input logic [6:0] op, input logic [2:0] f3,
                                              input logic b30);
        logic [3:0] code;
        code = 4'd0;
        if ((op == OP_R) || (op == OP_IMM)) begin
            case (f3)
                3'd0:    code = ((op == OP_R) && b30) ? 4'd1 : 4'd0;
                3'd1:    code = 4'd2;
                3'd2:    code = 4'd3;
                3'd3:    code = 4'd4;
                3'd4:    code = 4'd5;
                3'd5:    code = b30 ? 4'd7 : 4'd6;
                3'd6:    code = 4'd8;
                3'd7:    code = 4'd9;
                default: code = 4'd0;
            endcase
        end else begin
            code = 4'd0;
        end
        return code;
    endfunction

    assign opcode_s            = instr[6:0];
    assign funct3_s            = instr[14:12];
    assign illegal_enc_s       = enc_illegal(opcode_s, funct3_s);
    assign alu_op_s            = alu_decode(opcode_s, funct3_s, instr[30]);
    assign unused_instr_bits_s = ^{instr[31], instr[29:15], instr[11:7]};

    // ALU operand selects decoded from the opcode.
    always_comb begin
        alu_src_a_s = 2'b00;
        alu_src_b_s = 2'b00;
        case (opcode_s)
            OP_R: begin
                alu_src_a_s = 2'b00;
                alu_src_b_s = 2'b00;
            end
            OP_IMM, OP_LOAD, OP_STORE, OP_JALR: begin
                alu_src_a_s = 2'b00;
                alu_src_b_s = 2'b01;
            end
            OP_LUI: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
            end
            OP_AUIPC, OP_JAL, OP_BRANCH: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
            end
            default: begin
                alu_src_a_s = 2'b00;
                alu_src_b_s = 2'b00;
            end
        endcase
    end

    // State sequencing and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= FETCH;
            retire_cnt_r <= 32'd0;
        end else begin
            case (state_r)
                FETCH:  state_r <= mem_ready ? DECODE : FETCH;
                DECODE: begin
                    if (illegal_enc_s) begin
`ifdef RV_CTRL_TRAP_EN
                        state_r <= TRAP;
`else
                        state_r <= WB;
`endif
                    end else begin
                        state_r <= EXEC;
                    end
                end
                EXEC:   state_r <= ((opcode_s == OP_LOAD) || (opcode_s == OP_STORE)) ? MEM : WB;
                MEM:    state_r <= mem_ready ? WB : MEM;
                WB: begin
                    state_r      <= FETCH;
                    retire_cnt_r <= retire_cnt_r + 32'd1;
                end
`ifdef RV_CTRL_TRAP_EN
                TRAP:   state_r <= TRAP;
`endif
                default: state_r <= FETCH;
            endcase
        end
    end

    // Datapath controls decoded from the state; rst forces everything low in the same cycle.
    always_comb begin
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        ir_we        = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_size     = 2'b00;
        mem_unsigned = 1'b0;
        alu_op       = 4'd0;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        rf_we        = 1'b0;
        wb_sel       = 2'b00;
        instr_done   = 1'b0;
        illegal      = 1'b0;
        retire_cnt   = 32'd0;
        if (rst) begin
            retire_cnt = 32'd0;
        end else begin
            retire_cnt = retire_cnt_r;
            case (state_r)
                FETCH: begin
                    mem_req  = 1'b1;
                    mem_size = 2'b11;
                    ir_we    = mem_ready;
                end
                DECODE: begin
                    ir_we = 1'b0;
                end
                EXEC: begin
                    alu_op    = alu_op_s;
                    alu_src_a = alu_src_a_s;
                    alu_src_b = alu_src_b_s;
                end
                MEM: begin
                    // The ALU keeps producing the effective address for the memory port.
                    alu_op       = alu_op_s;
                    alu_src_a    = alu_src_a_s;
                    alu_src_b    = alu_src_b_s;
                    mem_req      = 1'b1;
                    mem_we       = (opcode_s == OP_STORE);
                    mem_unsigned = funct3_s[2];
                    case (funct3_s[1:0])
                        2'b00:   mem_size = 2'b00;
                        2'b01:   mem_size = 2'b01;
                        default: mem_size = 2'b11;
                    endcase
                end
                WB: begin
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                    if (illegal_enc_s) begin
                        rf_we = 1'b0;
                    end else begin
                        alu_op    = alu_op_s;
                        alu_src_a = alu_src_a_s;
                        alu_src_b = alu_src_b_s;
                        pc_sel    = (opcode_s == OP_JAL) || (opcode_s == OP_JALR) ||
                                    ((opcode_s == OP_BRANCH) && br_taken);
                        rf_we     = (opcode_s != OP_STORE) && (opcode_s != OP_BRANCH);
                        if (opcode_s == OP_LOAD) begin
                            wb_sel = 2'b01;
                        end else if ((opcode_s == OP_JAL) || (opcode_s == OP_JALR)) begin
                            wb_sel = 2'b10;
                        end else begin
                            wb_sel = 2'b00;
                        end
                    end
                end
`ifdef RV_CTRL_TRAP_EN
                TRAP: begin
                    illegal = 1'b1;
                end
`endif
                default: begin
                    illegal = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rv_multicycle_ctrl.md
# rv_multicycle_ctrl

Multi-cycle control FSM for the RV32I core. Sequences the shared datapath (PC, instruction register, register file, single ALU, unified memory port) through fetch, decode, execute, memory and write-back. Drives every datapath select and write enable from the current state and the latched instruction. It also traps illegal encodings and counts retired instructions.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr`  in  32  instruction register contents from the datapath; valid from DECODE onward.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `br_taken`  in  1  datapath comparator result for `instr[14:12]` (BEQ/BNE/BLT/BGE/BLTU/BGEU).
- `pc_we`  out  1  PC write enable.
- `pc_sel`  out  1  PC source: 0 = PC+4, 1 = ALU result.
- `ir_we`  out  1  instruction register write enable.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  memory write (store).
- `mem_size`  out  2  access size: 00 byte, 01 half word, 11 word.
- `mem_unsigned`  out  1  zero-extend load data.
- `alu_op`  out  4  ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
- `alu_src_a`  out  2  operand A: 00 rs1, 01 PC, 10 zero.
- `alu_src_b`  out  2  operand B: 00 rs2, 01 immediate, 10 constant 4.
- `rf_we`  out  1  register file write enable.
- `wb_sel`  out  2  write-back source: 00 ALU result, 01 load data, 10 PC+4.
- `instr_done`  out  1  one-cycle pulse when an instruction retires.
- `illegal`  out  1  sticky illegal-instruction flag.
- `retire_cnt`  out  32  count of retired instructions.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- **FETCH**
  - `mem_req`=1, `mem_we`=0, `mem_size`=11.
  - Hold until `mem_ready`. On that cycle: `ir_we`=1, go to DECODE.
- **DECODE**
  - Register read only.
  - Legal opcodes: 33, 03, 13, 67, 23, 63, 37, 17, 6F (hex).
  - Illegal encodings: any other opcode; load funct3 3/6/7; store funct3 ≥3; branch funct3 2/3.
  - Illegal encoding goes to TRAP; otherwise go to EXEC.
- **EXEC** `alu_op` mapping from funct3:
  - 0: ADD, or SUB when R-type and `instr[30]`.
  - 1: SLL. 2: SLT. 3: SLTU. 4: XOR.
  - 5: SRL, or SRA when `instr[30]` (R-type and I-type shifts).
  - 6: OR. 7: AND.
- **EXEC** operand selects (ALU ops not listed are ADD):
  - R-type: rs1/rs2.
  - I-ALU, load, store, JALR: rs1/imm.
  - LUI: zero/imm.
  - AUIPC, JAL, branch: PC/imm.
- **EXEC** next state: load and store go to MEM; all others go to WB.
- **MEM**
  - `mem_req`=1; `mem_we`=1 for store.
  - `mem_size` from funct3[1:0]: 00→00, 01→01, 10→11.
  - `mem_unsigned`=funct3[2].
  - Hold until `mem_ready`, then go to WB.
- **WB**
  - `pc_we`=1, `instr_done`=1, `retire_cnt`+1; go to FETCH.
  - `pc_sel`=1 for JAL and JALR, and for a branch with `br_taken`=1; otherwise 0.
  - `rf_we`=1 for all opcodes except store and branch.
  - `wb_sel`: 01 for load, 10 for JAL/JALR, 00 otherwise.
  - ALU inputs are held from EXEC, so the ALU result is still valid in WB.
- **TRAP**
  - `illegal`=1.
  - All enables and requests are 0; the FSM stays in TRAP until `rst`.
- Any output not explicitly driven in a state is 0.

## Timing
- While `rst`=1:
  - All outputs are 0, including `retire_cnt`=0 and `illegal`=0.
  - The state loads FETCH.
- The first cycle after `rst` falls is FETCH with `mem_req`=1.
- Cycle counts with zero-wait memory (`mem_ready` high in the first request cycle):
  - R, I-ALU, LUI, AUIPC, branch, JAL, JALR: 4 cycles.
  - Load and store: 5 cycles.
- Each wait cycle of `mem_ready`=0 adds one cycle.
- `mem_req`, `mem_we`, `mem_size` and `mem_unsigned` stay stable until `mem_ready`.
- `mem_ready` outside FETCH and MEM is ignored.
- `ir_we` and the FETCH→DECODE transition are combinational on `mem_ready`.
- `rst` asserted mid-request abandons the request: `mem_req` is 0 in the same cycle and the FSM restarts in FETCH.
- `retire_cnt` wraps from FFFFFFFF to 0.

## Configuration
- `RV_CTRL_TRAP_EN` defined: behaviour as specified above; illegal encodings enter TRAP.
- `RV_CTRL_TRAP_EN` undefined:
  - TRAP is not implemented and `illegal` is tied to 0.
  - An illegal encoding goes DECODE→WB with `rf_we`=0 and `pc_sel`=0, so it retires as a NOP with PC+4.
  - `instr_done` pulses and `retire_cnt` increments for it.

## Test plan
- `add x3,x1,x2` (002081B3), zero-wait memory:
  - EXEC: `alu_op`=0, `alu_src_a`=00, `alu_src_b`=00.
  - WB: `rf_we`=1, `wb_sel`=00, `pc_sel`=0.
  - `instr_done` on cycle 4; `retire_cnt`=1.
- `sub x2,x1,x2` (40208133): `alu_op`=1 in EXEC.
- `lw x2,0(x1)` (0000A103) with `mem_ready` low for 2 MEM cycles:
  - MEM: `mem_req`=1, `mem_we`=0, `mem_size`=11, `mem_unsigned`=0, held stable while waiting.
  - WB: `wb_sel`=01.
  - Total 7 cycles.
- `beq x0,x0,8` (00000463):
  - With `br_taken`=1: WB has `pc_sel`=1, `rf_we`=0.
  - With `br_taken`=0: WB has `pc_sel`=0.
- Instruction FFFFFFFF:
  - With `RV_CTRL_TRAP_EN`: `illegal` is 1 from the cycle after DECODE, stays 1 for 10 cycles, `mem_req` stays 0; `rst` clears it.
  - Without `RV_CTRL_TRAP_EN`: 3-cycle NOP, `retire_cnt` increments.
- `rst` pulsed during a MEM wait of a store: the next cycle is FETCH, `mem_we`=0, and `retire_cnt`=0.
